// File: rtl/l2_cache_arrays_pkg.sv
// l2_cache_arrays_pkg: geometry shared by the cache array top and its bus interface
package l2_cache_arrays_pkg;
  localparam int s_index = 3;
  localparam int s_offset = 5;
  localparam int tag_w = 24;
  localparam int s_mask = 2 ** s_offset;
  localparam int s_line = 8 * s_mask;
endpackage

// File: rtl/l2_cache_arrays_if.sv
// l2_cache_arrays_if: read/write ports of the metadata array and the line data array
interface l2_cache_arrays_if;
  import l2_cache_arrays_pkg::*;
  logic read;
  logic load;
  logic [s_index-1:0] rindex;
  logic [s_index-1:0] windex;
  logic [tag_w-1:0] datain;
  logic [tag_w-1:0] dataout;
  logic d_read;
  logic [s_mask-1:0] write_en;
  logic [s_index-1:0] d_rindex;
  logic [s_index-1:0] d_windex;
  logic [s_line-1:0] d_datain;
  logic [s_line-1:0] d_dataout;
  modport master (
    output read, load, rindex, windex, datain, d_read, write_en, d_rindex, d_windex, d_datain,
    input dataout, d_dataout
  );
  modport slave (
    input read, load, rindex, windex, datain, d_read, write_en, d_rindex, d_windex, d_datain,
    output dataout, d_dataout
  );
endinterface

// File: rtl/l2_cache_arrays_mem.sv
// l2_cache_arrays_mem: per-set metadata register file and byte-writable line store,
// both with a registered read port and write-first forwarding
module l2_array #(
  parameter int s_index = 3,
  parameter int width = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read,
  input  logic               load,
  input  logic [s_index-1:0] rindex,
  input  logic [s_index-1:0] windex,
  input  logic [width-1:0]   datain,
  output logic [width-1:0]   dataout
);
  localparam int num_sets = 2 ** s_index;
  logic [width-1:0] data [num_sets];
  logic [width-1:0] dout;
  assign dataout = dout;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < num_sets; i++) data[i] <= '0;
      dout <= '0;
    end else begin
      if (load) data[windex] <= datain;
      if (read) dout <= (load && rindex == windex) ? datain : data[rindex];
    end
  end
endmodule

module l2_data_array #(
  parameter int s_offset = 5,
  parameter int s_index = 3
) (
  input  logic                    clk,
  input  logic                    read,
  input  logic [2**s_offset-1:0]  write_en,
  input  logic [s_index-1:0]      rindex,
  input  logic [s_index-1:0]      windex,
  input  logic [8*2**s_offset-1:0] datain,
  output logic [8*2**s_offset-1:0] dataout
);
  localparam int s_mask = 2 ** s_offset;
  localparam int s_line = 8 * s_mask;
  localparam int num_sets = 2 ** s_index;
  // No reset: contents start at zero and valid bits elsewhere mask stale lines
  logic [s_line-1:0] data [num_sets] = '{default: '0};
  logic [s_line-1:0] dout = '0;
  logic [s_line-1:0] fwd;
  assign dataout = dout;
  for (genvar b = 0; b < s_mask; b++) begin : g_lane
    assign fwd[8*b +: 8] = (write_en[b] && rindex == windex) ? datain[8*b +: 8] : data[rindex][8*b +: 8];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < s_mask; i++) if (write_en[i]) data[windex][8*i +: 8] <= datain[8*i +: 8];
    if (read) dout <= fwd;
  end
endmodule

// File: rtl/l2_cache_arrays.sv
// l2_cache_arrays: one tag/metadata array and one line data array behind a shared bus
module l2_cache_arrays
  import l2_cache_arrays_pkg::*;
(
  input logic clk,
  input logic rst,
  l2_cache_arrays_if.slave bus
);
  l2_array #(.s_index(s_index), .width(tag_w)) u_meta (
    .clk(clk), .rst(rst), .read(bus.read), .load(bus.load),
    .rindex(bus.rindex), .windex(bus.windex), .datain(bus.datain), .dataout(bus.dataout)
  );
  l2_data_array #(.s_offset(s_offset), .s_index(s_index)) u_data (
    .clk(clk), .read(bus.d_read), .write_en(bus.write_en),
    .rindex(bus.d_rindex), .windex(bus.d_windex), .datain(bus.d_datain), .dataout(bus.d_dataout)
  );
endmodule

// File: tb/tb_l2_cache_arrays.sv
// tb_l2_cache_arrays: directed vector table for the metadata array, hand sequences for the line store
module tb_l2_cache_arrays;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int passed = 0;
  l2_cache_arrays_if bus ();
  l2_cache_arrays dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic rst, read, load;
    logic [2:0] rindex, windex;
    logic [23:0] datain, exp;
    string name;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(logic r, logic rd, logic ld, logic [2:0] ri, logic [2:0] wi,
                              logic [23:0] di, logic [23:0] ex, string nm);
    vec_t t;
    t.rst = r; t.read = rd; t.load = ld; t.rindex = ri; t.windex = wi;
    t.datain = di; t.exp = ex; t.name = nm;
    return t;
  endfunction
  task automatic chk(string name, logic [255:0] got, logic [255:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask
  task automatic dstep(logic rd, logic [31:0] we, logic [2:0] ri, logic [2:0] wi, logic [255:0] di);
    bus.d_read = rd; bus.write_en = we; bus.d_rindex = ri; bus.d_windex = wi; bus.d_datain = di;
    @(posedge clk);
    #1;
  endtask
  logic [255:0] l6, p6, exp6;
  initial begin
    bus.read = 1'b0; bus.load = 1'b0; bus.rindex = '0; bus.windex = '0; bus.datain = '0;
    bus.d_read = 1'b0; bus.write_en = '0; bus.d_rindex = '0; bus.d_windex = '0; bus.d_datain = '0;
    v.push_back(mk(1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 24'hFFFFFF, 24'h0, "reset"));
    for (int i = 0; i < 8; i++) v.push_back(mk(1'b0, 1'b1, 1'b0, 3'(i), 3'd0, 24'h0, 24'h0, "reset_read"));
    v.push_back(mk(1'b0, 1'b0, 1'b1, 3'd0, 3'd3, 24'hABCDEF, 24'h0, "write_no_read"));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 24'h0, 24'hABCDEF, "read_back"));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 3'd2, 3'd0, 24'h0, 24'h0, "read_other"));
    v.push_back(mk(1'b0, 1'b1, 1'b1, 3'd5, 3'd5, 24'h000001, 24'h000001, "forward"));
    v.push_back(mk(1'b0, 1'b0, 1'b1, 3'd5, 3'd5, 24'h0, 24'h000001, "hold"));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 3'd5, 3'd0, 24'h0, 24'h0, "hold_write_landed"));
    v.push_back(mk(1'b0, 1'b0, 1'b1, 3'd0, 3'd4, 24'h111111, 24'h0, "b2b_w1"));
    v.push_back(mk(1'b0, 1'b0, 1'b1, 3'd0, 3'd4, 24'h222222, 24'h0, "b2b_w2"));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 3'd4, 3'd0, 24'h0, 24'h222222, "b2b_last_wins"));
    v.push_back(mk(1'b0, 1'b1, 1'b1, 3'd3, 3'd1, 24'h333333, 24'hABCDEF, "indep_rw"));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 24'h0, 24'h333333, "indep_written"));
    v.push_back(mk(1'b1, 1'b1, 1'b1, 3'd6, 3'd6, 24'h444444, 24'h0, "rst_over_load"));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 3'd6, 3'd0, 24'h0, 24'h0, "rst_entry_zero"));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 24'h0, 24'h0, "rst_cleared"));
    @(posedge clk);
    #1;
    foreach (v[k]) begin
      rst = v[k].rst; bus.read = v[k].read; bus.load = v[k].load;
      bus.rindex = v[k].rindex; bus.windex = v[k].windex; bus.datain = v[k].datain;
      @(posedge clk);
      #1;
      chk(v[k].name, 256'(bus.dataout), 256'(v[k].exp));
    end
    rst = 1'b0; bus.read = 1'b0; bus.load = 1'b0;
    dstep(1'b1, 32'h0, 3'd7, 3'd0, '0);
    chk("data_init_zero", bus.d_dataout, '0);
    dstep(1'b0, 32'hFFFF_FFFF, 3'd0, 3'd2, '0);
    dstep(1'b0, 32'h0000_0001, 3'd0, 3'd2, {248'h0, 8'h5A});
    dstep(1'b1, 32'h0, 3'd2, 3'd0, '0);
    chk("byte_merge", bus.d_dataout, {248'h0, 8'h5A});
    l6 = {8{32'h11223344}};
    p6 = {8{32'hAABBCCDD}};
    exp6 = {32'hAABBCCDD, {7{32'h11223344}}};
    dstep(1'b0, 32'hFFFF_FFFF, 3'd0, 3'd6, l6);
    dstep(1'b1, 32'hF000_0000, 3'd6, 3'd6, p6);
    chk("byte_forward", bus.d_dataout, exp6);
    dstep(1'b1, 32'h0, 3'd6, 3'd0, '0);
    chk("byte_forward_stored", bus.d_dataout, exp6);
    dstep(1'b1, 32'hFFFF_FFFF, 3'd2, 3'd1, p6);
    chk("data_indep", bus.d_dataout, {248'h0, 8'h5A});
    dstep(1'b0, 32'hFFFF_FFFF, 3'd2, 3'd2, {256{1'b1}});
    chk("data_hold", bus.d_dataout, {248'h0, 8'h5A});
    dstep(1'b1, 32'h0, 3'd2, 3'd2, p6);
    chk("data_no_write", bus.d_dataout, {256{1'b1}});
    dstep(1'b1, 32'h0, 3'd1, 3'd0, '0);
    chk("data_line_fill", bus.d_dataout, p6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
